axis_loop_fifo: RTL
===================

# axis_loop_fifo

Parametrised AXI4-Stream loopback core: accepts beats on a slave stream, buffers them in a DEPTH-entry FIFO, optionally transforms the data, and returns them on a master stream. It is the datapath successor of the fixed 32-bit stream loop IP. Its control and status ports are wired to the IP's AXI4-Lite register block (enable, mode, flush, counter clear, fill level, beat/packet counters). Unlike the previous generation it has configurable width and depth, data transforms, backpressure-safe buffering and traffic counters.

## Interface
- DATA_WIDTH, 32, stream data width in bits; multiple of 8, 8..512
- DEPTH, 16, FIFO entries; power of two, 2..1024
- CNT_WIDTH, 32, width of beat/packet counters
- Clocking and reset: one clock; reset is synchronous and active-high.
- ACLK  in  1  clock; all logic on rising edge
- ARESET  in  1  synchronous active-high reset
- S_AXIS_TDATA  in  DATA_WIDTH  input beat data
- S_AXIS_TKEEP  in  DATA_WIDTH/8  byte qualifiers, stored unmodified
- S_AXIS_TLAST  in  1  end of packet
- S_AXIS_TVALID  in  1  input beat valid
- S_AXIS_TREADY  out  1  core can accept
- M_AXIS_TDATA  out  DATA_WIDTH  output beat data
- M_AXIS_TKEEP  out  DATA_WIDTH/8  output byte qualifiers
- M_AXIS_TLAST  out  1  end of packet
- M_AXIS_TVALID  out  1  output beat valid
- M_AXIS_TREADY  in  1  downstream accepts
- ENABLE  in  1  level; 0 stalls input side only
- MODE  in  2  transform: 0 pass, 1 bitwise invert, 2 byte reverse, 3 pass (reserved)
- FLUSH  in  1  single-cycle pulse; discard FIFO contents
- CLR_CNT  in  1  single-cycle pulse; zero counters
- FILL_LEVEL  out  clog2(DEPTH)+1  entries currently stored
- BEAT_CNT  out  CNT_WIDTH  output beats transferred
- PKT_CNT  out  CNT_WIDTH  output beats with TLAST transferred

## Operation
- Input handshake: S_AXIS_TREADY = ENABLE & !full & !FLUSH, combinational from registered state. A beat is accepted when TVALID & TREADY.
- Transform is applied at acceptance using MODE sampled in the same cycle. A MODE change never alters beats already stored.
  - Byte reverse: byte k goes to byte DATA_WIDTH/8-1-k.
  - TKEEP and TLAST are never transformed.
- Storage: circular buffer with clog2(DEPTH)-bit read/write pointers that wrap DEPTH-1 -> 0, plus an occupancy counter 0..DEPTH.
  - full = (occupancy == DEPTH); empty = (occupancy == 0).
- No push while full, even if a pop occurs in the same cycle. Push and pop in the same non-full, non-empty cycle leave occupancy unchanged.
- Output: M_AXIS_TVALID = !empty. M_AXIS_TDATA/TKEEP/TLAST present the head entry. Pop on TVALID & TREADY.
- Output side ignores ENABLE: stored data drains while ENABLE=0.
- FLUSH:
  - Pointers and occupancy are cleared at the next edge, and any push or pop in that cycle is suppressed.
  - Counters are not affected.
  - FLUSH is the only event allowed to drop M_AXIS_TVALID without a handshake. Control software issues it only with downstream idle.
- Counters:
  - BEAT_CNT increments on each output handshake; PKT_CNT increments on each output handshake with TLAST=1.
  - Both wrap modulo 2^CNT_WIDTH.
  - CLR_CNT zeroes both at the next edge. A handshake in the same cycle is not counted.

## Timing
- Reset values: S_AXIS_TREADY=0 while ARESET=1. M_AXIS_TVALID=0, FILL_LEVEL=0, BEAT_CNT=0, PKT_CNT=0. M_AXIS_TDATA/TKEEP/TLAST don't-care while TVALID=0.
- Reset asserted mid-operation discards all stored beats and clears counters at that edge. No partial packet survives.
- Latency: a beat accepted at edge N (FIFO previously empty) is presented with M_AXIS_TVALID=1 after edge N, i.e. one cycle.
- Throughput: one beat per cycle sustained when downstream is always ready.
- FILL_LEVEL is registered and reflects pushes/pops of the previous edge.
- Full boundary: with occupancy=DEPTH, S_AXIS_TREADY=0. It returns to 1 the cycle after the first pop.
- Empty boundary: with occupancy=0, M_AXIS_TVALID=0 and M_AXIS_TREADY is ignored.
- Simultaneous FLUSH and CLR_CNT: both take effect at the same edge.

## Test plan
- Pass-through with DATA_WIDTH=32, DEPTH=16, MODE=0, M_AXIS_TREADY=1: send 0x00000001..0x00000004 with TLAST on the 4th beat.
  - Required: identical words out, first beat one cycle after acceptance, BEAT_CNT=4, PKT_CNT=1.
- Transforms: MODE=1 with input 0x12345678 -> 0xEDCBA987. MODE=2 with input 0x12345678 -> 0x78563412.
  - Switch MODE while two beats are stored: those two keep their original transform.
- Full/backpressure with M_AXIS_TREADY=0: push 20 beats.
  - Required: exactly 16 accepted, S_AXIS_TREADY=0 and FILL_LEVEL=16.
  - Then release TREADY: all 16 drain in order with no loss, and TREADY rises one cycle after the first pop.
- Wrap-around: 3×DEPTH beats with random TREADY/TVALID gaps.
  - Required: output sequence equals input sequence and FILL_LEVEL never exceeds DEPTH.
- Control events with 5 beats stored:
  - ENABLE=0: input stalls while output drains.
  - FLUSH: FILL_LEVEL=0 and M_AXIS_TVALID=0 next cycle, counters unchanged.
  - CLR_CNT coincident with a TLAST handshake: BEAT_CNT=PKT_CNT=0.
- Reset mid-packet after 3 beats: ARESET for one cycle.
  - Required: all outputs at reset values, and a following packet is returned intact.

Source files
------------

// File: rtl/axis_loop_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : axis_loop_fifo
//  Description : AXI4-Stream loopback with DEPTH-entry FIFO, per-beat data
//                transform on entry, and output beat/packet counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_loop_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESET,

    input  logic [DATA_WIDTH-1:0]     S_AXIS_TDATA,
    input  logic [DATA_WIDTH/8-1:0]   S_AXIS_TKEEP,
    input  logic                      S_AXIS_TLAST,
    input  logic                      S_AXIS_TVALID,
    output logic                      S_AXIS_TREADY,

    output logic [DATA_WIDTH-1:0]     M_AXIS_TDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXIS_TKEEP,
    output logic                      M_AXIS_TLAST,
    output logic                      M_AXIS_TVALID,
    input  logic                      M_AXIS_TREADY,

    input  logic                      ENABLE,
    input  logic [1:0]                MODE,
    input  logic                      FLUSH,
    input  logic                      CLR_CNT,
    output logic [$clog2(DEPTH):0]    FILL_LEVEL,
    output logic [CNT_WIDTH-1:0]      BEAT_CNT,
    output logic [CNT_WIDTH-1:0]      PKT_CNT
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_LVL_W  = c_ADDR_W + 1;
    localparam int c_KEEP_W = DATA_WIDTH / 8;

    localparam logic [c_LVL_W-1:0]   c_LVL_FULL = c_LVL_W'(DEPTH);
    localparam logic [c_LVL_W-1:0]   c_LVL_ONE  = c_LVL_W'(1);
    localparam logic [c_ADDR_W-1:0]  c_PTR_ONE  = c_ADDR_W'(1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = CNT_WIDTH'(1);

    localparam logic [1:0] c_MODE_INV = 2'd1;
    localparam logic [1:0] c_MODE_REV = 2'd2;

    // Storage arrays
    logic [DATA_WIDTH-1:0] r_mem_data_q [DEPTH];
    logic [c_KEEP_W-1:0]   r_mem_keep_q [DEPTH];
    logic                  r_mem_last_q [DEPTH];

    // Pointer / occupancy / counter state
    logic [c_ADDR_W-1:0]  r_wr_ptr_q,   w_wr_ptr_d;
    logic [c_ADDR_W-1:0]  r_rd_ptr_q,   w_rd_ptr_d;
    logic [c_LVL_W-1:0]   r_count_q,    w_count_d;
    logic [CNT_WIDTH-1:0] r_beat_cnt_q, w_beat_cnt_d;
    logic [CNT_WIDTH-1:0] r_pkt_cnt_q,  w_pkt_cnt_d;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_rev_data;
    logic [DATA_WIDTH-1:0] w_xform_data;

    assign w_full  = (r_count_q == c_LVL_FULL);
    assign w_empty = (r_count_q == '0);

    // Reset term keeps the slave side closed for the whole reset cycle
    assign S_AXIS_TREADY = ENABLE & ~w_full & ~FLUSH & ~ARESET;
    assign M_AXIS_TVALID = ~w_empty;

    assign w_push = S_AXIS_TVALID & S_AXIS_TREADY;
    assign w_pop  = ~w_empty & M_AXIS_TREADY & ~FLUSH;

    for (genvar k = 0; k < c_KEEP_W; k++) begin : g_byte_rev
        assign w_rev_data[8*k +: 8] = S_AXIS_TDATA[8*(c_KEEP_W-1-k) +: 8];
    end

    // Transform is applied on entry so a later MODE change leaves stored beats intact
    always_comb begin
        w_xform_data = S_AXIS_TDATA;
        case (MODE)
            c_MODE_INV: w_xform_data = ~S_AXIS_TDATA;
            c_MODE_REV: w_xform_data = w_rev_data;
            default:    w_xform_data = S_AXIS_TDATA;
        endcase
    end

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (FLUSH) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_count_d  = '0;
        end else begin
            if (w_push) begin
                w_wr_ptr_d = r_wr_ptr_q + c_PTR_ONE;
            end
            if (w_pop) begin
                w_rd_ptr_d = r_rd_ptr_q + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   w_count_d = r_count_q + c_LVL_ONE;
                2'b01:   w_count_d = r_count_q - c_LVL_ONE;
                default: w_count_d = r_count_q;
            endcase
        end
    end

    // Clear wins over a coincident handshake
    always_comb begin
        w_beat_cnt_d = r_beat_cnt_q;
        w_pkt_cnt_d  = r_pkt_cnt_q;
        if (CLR_CNT) begin
            w_beat_cnt_d = '0;
            w_pkt_cnt_d  = '0;
        end else if (w_pop) begin
            w_beat_cnt_d = r_beat_cnt_q + c_CNT_ONE;
            if (M_AXIS_TLAST) begin
                w_pkt_cnt_d = r_pkt_cnt_q + c_CNT_ONE;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wr_ptr_q   <= '0;
            r_rd_ptr_q   <= '0;
            r_count_q    <= '0;
            r_beat_cnt_q <= '0;
            r_pkt_cnt_q  <= '0;
        end else begin
            r_wr_ptr_q   <= w_wr_ptr_d;
            r_rd_ptr_q   <= w_rd_ptr_d;
            r_count_q    <= w_count_d;
            r_beat_cnt_q <= w_beat_cnt_d;
            r_pkt_cnt_q  <= w_pkt_cnt_d;
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_push) begin
            r_mem_data_q[r_wr_ptr_q] <= w_xform_data;
            r_mem_keep_q[r_wr_ptr_q] <= S_AXIS_TKEEP;
            r_mem_last_q[r_wr_ptr_q] <= S_AXIS_TLAST;
        end
    end

    assign M_AXIS_TDATA = r_mem_data_q[r_rd_ptr_q];
    assign M_AXIS_TKEEP = r_mem_keep_q[r_rd_ptr_q];
    assign M_AXIS_TLAST = r_mem_last_q[r_rd_ptr_q];

    assign FILL_LEVEL = r_count_q;
    assign BEAT_CNT   = r_beat_cnt_q;
    assign PKT_CNT    = r_pkt_cnt_q;

endmodule
`default_nettype wire
